// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared XOR cipher defaults, receiver state type and counter widths
package xor_cipher_pkg;

  localparam int KEY_W_DEF = 32;
  localparam int MSG_W_DEF = 512;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int KEY_CNT_W = cnt_w(KEY_W_DEF);
  localparam int BIT_CNT_W = cnt_w(MSG_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/xor_key_shift_reg.sv
// rtl/xor_key_shift_reg.sv - serial key shifter with load counter, valid flag and freeze
module xor_key_shift_reg
  import xor_cipher_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iLoad_key,
  input  logic             iKey_serial,
  input  logic             iFreeze,
  output logic [KEY_W-1:0] oKey,
  output logic             oKey_valid
);

  localparam int CW = cnt_w(KEY_W);

  logic [KEY_W-1:0] r_key;
  logic [CW-1:0]    r_cnt;
  logic             r_load_d;

  // Count saturates at KEY_W; a rising load restarts it so the new bit counts as the first.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_key    <= '0;
      r_cnt    <= '0;
      r_load_d <= 1'b0;
    end else begin
      r_load_d <= iLoad_key;
      if (iLoad_key && !iFreeze) begin
        r_key <= {r_key[KEY_W-2:0], iKey_serial};
        if (!r_load_d)
          r_cnt <= CW'(1);
        else if (r_cnt != CW'(KEY_W))
          r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign oKey       = r_key;
  assign oKey_valid = (r_cnt == CW'(KEY_W));

endmodule

// File: rtl/xor_decryption_rx.sv
// rtl/xor_decryption_rx.sv - serial XOR decryption receiver; XOR_DEC_SERIAL_OUT_EN adds a serial plaintext tap
module xor_decryption_rx
  import xor_cipher_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int MSG_W = MSG_W_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iLoad_key,
  input  logic             iKey_serial,
  input  logic             iSerial_in,
  input  logic             iSerial_valid,
  input  logic             iSerial_end,
`ifdef XOR_DEC_SERIAL_OUT_EN
  output logic             oPlain_serial,
  output logic             oPlain_valid,
`endif
  output logic             oKey_valid,
  output logic             oBusy,
  output logic [MSG_W-1:0] oPlaintext,
  output logic             oDone,
  output logic             oFrame_err
);

  localparam int CNT_W  = cnt_w(MSG_W);
  localparam int PIDX_W = $clog2(MSG_W);
  localparam int KIDX_W = $clog2(KEY_W);

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [MSG_W-1:0] r_plain;

  logic [KEY_W-1:0]  w_key;
  logic              w_key_valid;
  logic              w_busy;
  logic              w_start;
  logic              w_accept;
  logic              w_overflow;
  logic [CNT_W-1:0]  w_cnt_base;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_idx;
  logic [PIDX_W-1:0] w_pidx;
  logic [KIDX_W-1:0] w_kidx;
  logic              w_bit;

  xor_key_shift_reg #(.KEY_W(KEY_W)) u_key (
    .iClk        (iClk),
    .iRst        (iRst),
    .iLoad_key   (iLoad_key),
    .iKey_serial (iKey_serial),
    .iFreeze     (w_busy),
    .oKey        (w_key),
    .oKey_valid  (w_key_valid)
  );

  assign w_busy     = (r_state == RECV);
  assign w_start    = !w_busy && iSerial_valid;
  assign w_overflow = w_busy && iSerial_valid && (r_cnt == CNT_W'(MSG_W));
  assign w_accept   = w_start || (w_busy && iSerial_valid && !w_overflow);
  assign w_cnt_base = w_start ? '0 : r_cnt;
  assign w_cnt_next = w_cnt_base + CNT_W'(w_accept);

  // First received bit lands at MSB; the key repeats every KEY_W bits of the frame.
  assign w_idx  = CNT_W'(MSG_W - 1) - w_cnt_base;
  assign w_pidx = PIDX_W'(w_idx);
  assign w_kidx = KIDX_W'(w_idx % CNT_W'(KEY_W));
  assign w_bit  = iSerial_in ^ w_key[w_kidx];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_plain <= '0;
    end else begin
      if (w_start)
        r_plain <= '0;
      if (w_accept)
        r_plain[w_pidx] <= w_bit;
      if (w_start || w_busy)
        r_cnt <= w_cnt_next;
      if (w_start || w_busy) begin
        if (w_overflow)
          r_state <= ERR;
        else if (iSerial_end)
          r_state <= (w_cnt_next == CNT_W'(MSG_W) && w_key_valid) ? DONE : ERR;
        else
          r_state <= RECV;
      end
    end
  end

`ifdef XOR_DEC_SERIAL_OUT_EN
  logic r_plain_serial;
  logic r_plain_valid;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_plain_serial <= 1'b0;
      r_plain_valid  <= 1'b0;
    end else begin
      r_plain_valid <= w_accept;
      if (w_accept)
        r_plain_serial <= w_bit;
    end
  end

  assign oPlain_serial = r_plain_serial;
  assign oPlain_valid  = r_plain_valid;
`endif

  assign oKey_valid = w_key_valid;
  assign oBusy      = w_busy;
  assign oPlaintext = r_plain;
  assign oDone      = (r_state == DONE);
  assign oFrame_err = (r_state == ERR);

endmodule

// File: tb/tb_xor_decryption_rx.sv
// tb/tb_xor_decryption_rx.sv - scoreboard bench for xor_decryption_rx (XOR_DEC_SERIAL_OUT_EN optional)
module tb_xor_decryption_rx;

  localparam int KW = 32;
  localparam int MW = 512;
  localparam logic [KW-1:0] KEY = 32'hA5A5A5A5;
  localparam logic [MW-1:0] REP = {16{KEY}};
  localparam logic [MW-1:0] M = {
    32'hA3B1F9D2, 32'h5E6F7081, 32'h92A3B4C5, 32'hD6E7F809,
    32'h1A2B3C4D, 32'h5E6F7A8B, 32'h9CADBECF, 32'hD0E1F203,
    32'h14253647, 32'h58697A8B, 32'h9CADBECF, 32'h0F1E2D3C,
    32'h4B5A6978, 32'h8796A5B4, 32'hC3D2E1F0, 32'hC7D1F2E4};

  typedef struct {
    bit            done;
    bit            err;
    bit            chk_plain;
    logic [MW-1:0] plain;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_key = 1'b0;
  logic          key_serial = 1'b0;
  logic          ser_in = 1'b0;
  logic          ser_valid = 1'b0;
  logic          ser_end = 1'b0;
  logic          key_valid;
  logic          busy;
  logic [MW-1:0] plaintext;
  logic          done;
  logic          frame_err;
  logic          plain_serial;
  logic          plain_valid;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   sq[$];
  bit   ser_en = 1'b0;

  always #5 clk = ~clk;

  xor_decryption_rx #(.KEY_W(KW), .MSG_W(MW)) dut (
    .iClk          (clk),
    .iRst          (rst),
    .iLoad_key     (load_key),
    .iKey_serial   (key_serial),
    .iSerial_in    (ser_in),
    .iSerial_valid (ser_valid),
    .iSerial_end   (ser_end),
`ifdef XOR_DEC_SERIAL_OUT_EN
    .oPlain_serial (plain_serial),
    .oPlain_valid  (plain_valid),
`endif
    .oKey_valid    (key_valid),
    .oBusy         (busy),
    .oPlaintext    (plaintext),
    .oDone         (done),
    .oFrame_err    (frame_err)
  );

`ifndef XOR_DEC_SERIAL_OUT_EN
  assign plain_serial = 1'b0;
  assign plain_valid  = 1'b0;
`endif

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit d, input bit e, input bit cp, input logic [MW-1:0] p);
    exp_t x;
    x.done = d; x.err = e; x.chk_plain = cp; x.plain = p;
    q.push_back(x);
  endtask

  task automatic load(input logic [KW-1:0] k);
    load_key = 1'b1;
    for (int i = 0; i < KW; i++) begin
      key_serial = k[KW-1-i];
      tick();
    end
    load_key = 1'b0;
    key_serial = 1'b0;
  endtask

  // end_mode: 0 no end pulse, 1 end with last bit, 2 end one cycle after last bit
  task automatic send(input logic [MW-1:0] ct, input int nbits, input int end_mode, input bit toggle);
    for (int i = 0; i < nbits; i++) begin
      ser_valid  = 1'b1;
      ser_in     = (i < MW) ? ct[MW-1-i] : 1'b0;
      ser_end    = (end_mode == 1) && (i == nbits - 1);
      load_key   = toggle && (i >= 100) && (i < 110) && i[0];
      key_serial = i[1];
      tick();
      if (i == 0)
        chk("busy_mid_frame", busy, 1);
    end
    ser_valid = 1'b0; ser_in = 1'b0; ser_end = 1'b0; load_key = 1'b0;
    if (end_mode == 2) begin
      ser_end = 1'b1;
      tick();
      ser_end = 1'b0;
    end
  endtask

  initial begin : monitor
    logic [1:0] prev;
    exp_t       e;
    prev = 2'b00;
    forever begin
      @(negedge clk);
      if ({done, frame_err} != 2'b00 && prev == 2'b00) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result done=%0b err=%0b", done, frame_err);
        end else begin
          e = q.pop_front();
          chk("mon_done", done, e.done);
          chk("mon_err", frame_err, e.err);
          if (e.chk_plain)
            chk("mon_plain", plaintext, e.plain);
        end
      end
      prev = {done, frame_err};
    end
  end

  initial begin : serial_monitor
    forever begin
      @(negedge clk);
      if (plain_valid && ser_en) begin
        if (sq.size() == 0)
          chk("ser_extra", 1, 0);
        else
          chk("ser_bit", plain_serial, sq.pop_front());
      end
    end
  end

  initial begin : main
    tick();
    tick();
    rst = 1'b0;
    chk("rst_key_valid", key_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plain", plaintext, 0);
    chk("rst_done", done, 0);
    chk("rst_err", frame_err, 0);

    load(KEY);
    chk("key_valid_after_load", key_valid, 1);

    push(1, 0, 1, '0);
    send(REP, MW, 1, 0);
    chk("f1_done_next_cycle", done, 1);

    push(1, 0, 1, M);
    send(M ^ REP, MW, 2, 1);
    chk("f2_done_next_cycle", done, 1);
    chk("f2_plain", plaintext, M);
    chk("f2_key_valid_kept", key_valid, 1);

    push(0, 1, 0, '0);
    send(M ^ REP, MW - 1, 2, 0);
    chk("f3_err", frame_err, 1);
    chk("f3_done", done, 0);

    push(0, 1, 0, '0);
    send(M ^ REP, MW + 1, 0, 0);
    chk("f4_err_after_513", frame_err, 1);
    ser_end = 1'b1;
    tick();
    ser_end = 1'b0;
    tick();
    chk("f4_err_hold", frame_err, 1);
    chk("f4_done_hold", done, 0);
    chk("f4_busy", busy, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_key_valid", key_valid, 0);
    push(0, 1, 0, '0);
    send(M, MW, 1, 1);
    chk("f5_nokey_err", frame_err, 1);
    chk("f5_key_valid", key_valid, 0);

    load(KEY);
    send(M ^ REP, 200, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_key_valid", key_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_plain", plaintext, 0);
    chk("abort_done", done, 0);
    chk("abort_err", frame_err, 0);

    load(KEY);
    for (int i = 0; i < MW; i++)
      sq.push_back(M[MW-1-i]);
    ser_en = 1'b1;
    push(1, 0, 1, M);
    send(M ^ REP, MW, 1, 0);
    chk("f7_plain", plaintext, M);
    for (int i = 0; i < 4; i++)
      tick();
    chk("scoreboard_empty", q.size(), 0);
`ifdef XOR_DEC_SERIAL_OUT_EN
    chk("serial_queue_empty", sq.size(), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xor_decryption_rx.md
# xor_decryption_rx

Receive-side counterpart to the XOR encryption top. It loads a serial key and accepts the encryptor's serialized ciphertext frame (bit-valid strobe plus end pulse, MSB first). It decrypts each bit on the fly against the repeating key and presents the recovered plaintext in parallel, with done and frame-error flags. It sits at the far end of the serial link, feeding the host's message sink.

## Interface
Parameters:
- KEY_W, 32, key length in bits
- MSG_W, 512, frame length in bits; must be a multiple of KEY_W

Ports:
- iClk  input  1  system clock
- iRst  input  1  reset; synchronous, active-high
- iLoad_key  input  1  key load enable
- iKey_serial  input  1  key bit, MSB first, sampled while iLoad_key=1
- iSerial_in  input  1  ciphertext bit
- iSerial_valid  input  1  iSerial_in carries a valid bit this cycle (encryptor oSerial_start)
- iSerial_end  input  1  one-cycle end-of-frame pulse (encryptor oSerial_end)
- oKey_valid  output  1  full KEY_W-bit key held
- oBusy  output  1  frame in progress
- oPlaintext  output  MSG_W  decrypted frame; bit MSG_W-1 = first received
- oDone  output  1  frame complete and correct; level signal
- oFrame_err  output  1  frame rejected; level signal

## Operation
- Key load (sub-block): each cycle with iLoad_key=1 and state≠RECV, shift iKey_serial into the LSB and increment the 6-bit key count.
  - oKey_valid=1 once the count reaches KEY_W; further bits keep shifting, so the last KEY_W bits win.
  - A new load starting (iLoad_key rising) clears the count and oKey_valid.
  - iLoad_key is ignored in RECV; the key is frozen for the whole frame.
- FSM states: IDLE, RECV, DONE, ERR.
  - IDLE/DONE/ERR → RECV: first cycle with iSerial_valid=1. On entry, clear the bit count and oPlaintext, and drop oDone and oFrame_err.
  - RECV: each valid bit is stored at index j = MSG_W-1-count as iSerial_in ^ key[j mod KEY_W], then count increments. This matches an encryptor key of {MSG_W/KEY_W{key}}.
  - RECV → DONE: on iSerial_end, if count==MSG_W and oKey_valid=1.
  - RECV → ERR: on iSerial_end otherwise, on a valid bit when count==MSG_W (overflow), or if the frame started with oKey_valid=0.
- iSerial_end coinciding with the final valid bit: the bit is accepted first, then the end check runs, so a 512th bit plus end pulse gives DONE.
- iSerial_end in IDLE/DONE/ERR: ignored.
- Bit count width: $clog2(MSG_W+1), 10 bits at default. It never wraps; overflow goes to ERR.
- In ERR, oPlaintext holds whatever was received; consumers must ignore it.

## Timing
- Reset values: oKey_valid=0, oBusy=0, oPlaintext=0, oDone=0, oFrame_err=0, FSM=IDLE, both counters=0, key register=0.
- Reset mid-frame or mid-key-load aborts it completely; the key must be reloaded.
- Per-bit latency: the oPlaintext bit is updated at the clock edge that samples it (visible next cycle).
- oDone/oFrame_err assert in the cycle after the edge sampling iSerial_end (or the overflow bit), and hold until the next frame start or reset.
- oBusy is high exactly while FSM=RECV.
- Throughput: one bit per cycle, no back-pressure. Back-to-back frames are allowed: a valid bit the cycle after the end pulse starts a new frame.

## Configuration
- XOR_DEC_SERIAL_OUT_EN defined: adds ports oPlain_serial (1) and oPlain_valid (1). Each accepted bit's decrypted value appears one cycle after sampling, with oPlain_valid=1. Both reset to 0.
- Not defined: these ports and their registers are absent, and parallel behaviour is unchanged.

## Structure
- Shared package xor_cipher_pkg holds:
  - KEY_W and MSG_W defaults (shared with the encryptor)
  - the FSM state enum typedef (IDLE, RECV, DONE, ERR)
  - the bit-counter width localparams
- One sub-module, xor_key_shift_reg: the serial key shifter, counter and oKey_valid generation, with a freeze input driven by oBusy.

## Test plan
- Load key 0xA5A5A5A5, send 512-bit ciphertext {16{32'hA5A5A5A5}}, end pulse with the last bit → oDone=1, oFrame_err=0, oPlaintext=0.
- Load key 0xA5A5A5A5, send ciphertext = M ^ {16{key}} with M = 0xA3B1F9D2…C7D1F2E4, end pulse one cycle after the last bit → oPlaintext==M, oDone next cycle.
- Send only 511 bits, then end pulse → oFrame_err=1, oDone=0.
- Send 513 valid bits → oFrame_err=1 the cycle after bit 513; a later end pulse does not change state.
- Frame with no key loaded → oFrame_err=1 at end. Toggling iLoad_key mid-frame leaves the key and oKey_valid unchanged.
- Assert iRst at bit 200 → all outputs 0, FSM IDLE, oKey_valid=0. A reloaded key plus a full frame then decrypts correctly. With XOR_DEC_SERIAL_OUT_EN, the oPlain_serial stream equals M MSB first.
